// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad sequencer. Drives one row at a time (one-cold),
// hands the lowest closed column to an external column debouncer, emits a one-clk
// key_valid pulse with key_code on a confirmed press and tracks the key until the
// debouncer confirms release.
// Optional feature: define KEYPAD_SCAN_REPEAT_EN to add auto-repeat events while held.
module keypad_scanner #(
  parameter int unsigned SETTLE       = 2,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       deb_req,
  output logic [3:0] deb_active_col,
  input  logic       deb_high,
  input  logic       deb_low,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  // Elaboration-time sanity check on the timing parameters.
  if (SETTLE < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("keypad_scanner: SETTLE, REPEAT_DELAY and REPEAT_RATE must all be >= 1");
  end

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      row_idx;
  logic [1:0]      col_idx;
  logic [SW-1:0]   settle_cnt;

`ifdef KEYPAD_SCAN_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW      = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] RPT_DELAY_T = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_RATE_T  = RW'(REPEAT_RATE);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first;
  logic [RW-1:0] rpt_next;
  logic [RW-1:0] rpt_target;

  // Next repeat count and the interval currently being timed (first delay, then rate).
  always_comb begin
    rpt_next   = rpt_cnt + RW'(1);
    rpt_target = rpt_first ? RPT_DELAY_T : RPT_RATE_T;
  end
`endif

  // Lowest closed column wins when several are set.
  function automatic logic [1:0] lowest_bit(input logic [3:0] c);
    logic [1:0] idx;
    if (c[0])      idx = 2'd0;
    else if (c[1]) idx = 2'd1;
    else if (c[2]) idx = 2'd2;
    else           idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [3:0] one_cold(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Scan / press / held sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= SCAN;
      row            <= 4'b1110;
      row_idx        <= 2'd0;
      col_idx        <= 2'd0;
      settle_cnt     <= '0;
      deb_req        <= 1'b0;
      deb_active_col <= 4'b1111;
      key_valid      <= 1'b0;
      key_code       <= 4'b0000;
      key_held       <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
      rpt_cnt        <= '0;
      rpt_first      <= 1'b1;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (en) begin
            if (settle_cnt < SETTLE_LAST) begin
              settle_cnt <= settle_cnt + SW'(1);
            end else if (col != 4'b0000) begin
              col_idx        <= lowest_bit(col);
              deb_active_col <= one_cold(lowest_bit(col));
              deb_req        <= 1'b1;
              state          <= PRESS;
            end else begin
              row_idx    <= row_idx + 2'd1;
              row        <= one_cold(row_idx + 2'd1);
              settle_cnt <= '0;
            end
          end
        end
        PRESS: begin
          if (en) begin
            if (deb_high) begin
              key_code  <= {row_idx, col_idx};
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state     <= HELD;
`ifdef KEYPAD_SCAN_REPEAT_EN
              rpt_cnt   <= '0;
              rpt_first <= 1'b1;
`endif
            end else if (deb_low) begin
              deb_req        <= 1'b0;
              deb_active_col <= 4'b1111;
              row_idx        <= row_idx + 2'd1;
              row            <= one_cold(row_idx + 2'd1);
              settle_cnt     <= '0;
              state          <= SCAN;
            end
          end
        end
        HELD: begin
          if (en) begin
            if (deb_low) begin
              key_held       <= 1'b0;
              deb_req        <= 1'b0;
              deb_active_col <= 4'b1111;
              row_idx        <= row_idx + 2'd1;
              row            <= one_cold(row_idx + 2'd1);
              settle_cnt     <= '0;
              state          <= SCAN;
`ifdef KEYPAD_SCAN_REPEAT_EN
              rpt_cnt        <= '0;
              rpt_first      <= 1'b1;
            end else if (rpt_next == rpt_target) begin
              key_valid <= 1'b1;
              rpt_cnt   <= '0;
              rpt_first <= 1'b0;
            end else begin
              rpt_cnt <= rpt_next;
`endif
            end
          end
        end
        default: begin
          state          <= SCAN;
          row            <= 4'b1110;
          row_idx        <= 2'd0;
          settle_cnt     <= '0;
          deb_req        <= 1'b0;
          deb_active_col <= 4'b1111;
          key_held       <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
          rpt_cnt        <= '0;
          rpt_first      <= 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed scenarios with literal expectations, then randomized
// stimulus, all checked every cycle against a behavioural keypad model.
module tb_keypad_scanner;

  localparam int unsigned SETTLE       = 2;
  localparam int unsigned REPEAT_DELAY = 4;
  localparam int unsigned REPEAT_RATE  = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic [3:0] col;
  logic [3:0] row;
  logic       deb_req;
  logic [3:0] deb_active_col;
  logic       deb_high;
  logic       deb_low;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  keypad_scanner #(
    .SETTLE       (SETTLE),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .en             (en),
    .col            (col),
    .row            (row),
    .deb_req        (deb_req),
    .deb_active_col (deb_active_col),
    .deb_high       (deb_high),
    .deb_low        (deb_low),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .key_held       (key_held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = scanning, 1 = awaiting debounce, 2 = key held.
  int m_mode, m_row, m_settle, m_col, m_code, m_ticks;
  bit m_valid;

  function automatic int lowest(input logic [3:0] c);
    int r = 0;
    for (int i = 3; i >= 0; i--) if (c[i]) r = i;
    return r;
  endfunction

  function automatic bit repeat_due(input int t);
`ifdef KEYPAD_SCAN_REPEAT_EN
    return (t == REPEAT_DELAY) ||
           (t > REPEAT_DELAY && ((t - REPEAT_DELAY) % REPEAT_RATE) == 0);
`else
    return (t < 0);
`endif
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      m_mode = 0; m_row = 0; m_settle = 0; m_col = 0; m_code = 0; m_valid = 0; m_ticks = 0;
    end else begin
      m_valid = 0;
      if (en) begin
        if (m_mode == 0) begin
          if (m_settle < SETTLE - 1) m_settle++;
          else if (col != 4'b0000) begin m_col = lowest(col); m_mode = 1; end
          else begin m_row = (m_row + 1) % 4; m_settle = 0; end
        end else if (m_mode == 1) begin
          if (deb_high) begin
            m_code = m_row * 4 + m_col; m_valid = 1; m_mode = 2; m_ticks = 0;
          end else if (deb_low) begin
            m_mode = 0; m_row = (m_row + 1) % 4; m_settle = 0;
          end
        end else begin
          if (deb_low) begin
            m_mode = 0; m_row = (m_row + 1) % 4; m_settle = 0;
          end else begin
            m_ticks++;
            if (repeat_due(m_ticks)) m_valid = 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [3:0] e_row, e_act;
    if (chk_on) begin
      e_row = 4'hF ^ (4'b0001 << m_row);
      e_act = (m_mode == 0) ? 4'hF : (4'hF ^ (4'b0001 << m_col));
      chk("row", row, e_row);
      chk("deb_req", {3'b0, deb_req}, {3'b0, m_mode != 0});
      chk("deb_active_col", deb_active_col, e_act);
      chk("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
      chk("key_code", key_code, 4'(m_code));
      chk("key_held", {3'b0, key_held}, {3'b0, m_mode == 2});
    end
  end

  // Apply en for one clock; returns just after the following falling edge.
  task automatic cyc(input logic e);
    en = e;
    @(negedge clk);
    #1;
  endtask

  logic [3:0] idle_rows [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [9:0] vmask;
  logic [9:0] exp_mask;

  initial begin
    rstn = 1'b0; en = 1'b0; col = 4'b0; deb_high = 1'b0; deb_low = 1'b0;
    cyc(0); cyc(0);
    chk_on = 1'b1;
    chk("rst_row", row, 4'b1110);
    chk("rst_held", {3'b0, key_held}, 4'b0);
    rstn = 1'b1;

    // Idle scan: en every 4 clk, row advances every 2nd tick.
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      if (k % 2 == 0) chk("idle_row", row, idle_rows[k/2 - 1]);
      repeat (3) cyc(0);
    end

    // Press on row 2, column 1.
    repeat (5) cyc(1);
    chk("settled_row", row, 4'b1011);
    col = 4'b0010; cyc(1);
    chk("press_req", {3'b0, deb_req}, 4'b0001);
    chk("press_active", deb_active_col, 4'b1101);
    chk("press_no_valid", {3'b0, key_valid}, 4'b0);
    deb_high = 1'b1; cyc(1);
    deb_high = 1'b0; col = 4'b0;
    chk("event_valid", {3'b0, key_valid}, 4'b0001);
    chk("event_code", key_code, 4'b1001);
    chk("model_code", 4'(m_code), 4'b1001);
    chk("event_held", {3'b0, key_held}, 4'b0001);
    cyc(0);
    chk("valid_one_clk", {3'b0, key_valid}, 4'b0);

    // In HELD, deb_high pulses produce nothing; deb_low releases.
    deb_high = 1'b1; cyc(1); cyc(0); deb_high = 1'b0;
    chk("held_no_refire", {3'b0, key_valid}, 4'b0);
    deb_low = 1'b1; cyc(1); deb_low = 1'b0;
    chk("release_held", {3'b0, key_held}, 4'b0);
    chk("release_code", key_code, 4'b1001);
    chk("release_row", row, 4'b0111);

    // Bounce abort with col=0110 locking column 1.
    cyc(1);
    col = 4'b0110; cyc(1); col = 4'b0;
    chk("lock_active", deb_active_col, 4'b1101);
    deb_low = 1'b1; cyc(1); deb_low = 1'b0;
    chk("bounce_req", {3'b0, deb_req}, 4'b0);
    chk("bounce_valid", {3'b0, key_valid}, 4'b0);
    chk("bounce_row", row, 4'b1110);

    // deb_high and deb_low together: deb_high wins.
    cyc(1);
    col = 4'b0100; cyc(1); col = 4'b0;
    deb_high = 1'b1; deb_low = 1'b1; cyc(1); deb_high = 1'b0; deb_low = 1'b0;
    chk("prio_valid", {3'b0, key_valid}, 4'b0001);
    chk("prio_code", key_code, 4'b0010);

    // Hold for 10 en ticks; record which ticks produce key_valid.
    vmask = '0;
    for (int k = 0; k < 10; k++) begin
      deb_high = 1'($urandom_range(0, 1));
      cyc(1);
      vmask[k] = key_valid;
    end
    deb_high = 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
    exp_mask = 10'b10_1010_1000;
`else
    exp_mask = 10'b00_0000_0000;
`endif
    chk("repeat_lo", vmask[3:0], exp_mask[3:0]);
    chk("repeat_mid", vmask[7:4], exp_mask[7:4]);
    chk("repeat_hi", {2'b0, vmask[9:8]}, {2'b0, exp_mask[9:8]});
    deb_low = 1'b1; cyc(1); deb_low = 1'b0;
    chk("rpt_release_code", key_code, 4'b0010);

    // Reset for 3 clk while in PRESS.
    cyc(1);
    col = 4'b0001; cyc(1); col = 4'b0;
    chk("pre_reset_req", {3'b0, deb_req}, 4'b0001);
    rstn = 1'b0; cyc(1); cyc(0); cyc(1); rstn = 1'b1;
    chk("reset_row", row, 4'b1110);
    chk("reset_req", {3'b0, deb_req}, 4'b0);
    chk("reset_active", deb_active_col, 4'b1111);
    chk("reset_valid", {3'b0, key_valid}, 4'b0);
    chk("reset_code", key_code, 4'b0000);
    chk("reset_held", {3'b0, key_held}, 4'b0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 4000; i++) begin
      rstn     = ($urandom_range(0, 599) != 0);
      col      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      deb_high = ($urandom_range(0, 6) == 0);
      deb_low  = ($urandom_range(0, 11) == 0);
      cyc(1'($urandom_range(0, 1)));
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
